// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle datapath control FSM with exception handling
module controle_multiciclo (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic [2:0] ULAcontrole,
  output logic       ULASrcA,
  output logic [1:0] ULASrcB,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       excecao,
  output logic [3:0] estado
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_EXCECAO  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;
  logic   ovf_reg_q, ovf_reg_d;

  logic       funct_legal;
  logic       funct_arith;
  logic [2:0] funct_alu;

  // Decode funct into an ALU op and classify it (legal / overflow-capable)
  always_comb begin
    funct_legal = 1'b1;
    funct_arith = 1'b0;
    funct_alu   = 3'b000;
    case (funct)
      FN_ADD: begin funct_alu = ALU_ADD; funct_arith = 1'b1; end
      FN_SUB: begin funct_alu = ALU_SUB; funct_arith = 1'b1; end
      FN_AND: funct_alu = ALU_AND;
      FN_OR:  funct_alu = ALU_OR;
      FN_SLT: funct_alu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  // State and overflow flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ovf_reg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ovf_reg_q <= ovf_reg_d;
    end
  end

  // Next-state selection and overflow flag capture/clear
  always_comb begin
    state_d   = state_q;
    ovf_reg_d = ovf_reg_q;
    case (state_q)
      S_FETCH: begin
        state_d   = S_DECODE;
        ovf_reg_d = 1'b0;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_EXCECAO;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTE: begin
        if (funct_legal) begin
          state_d = S_ALUWB;
          if (funct_arith) ovf_reg_d = overflow;
        end else begin
          state_d = S_EXCECAO;
        end
      end
      S_ALUWB:    state_d = ovf_reg_q ? S_EXCECAO : S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: begin
        state_d   = S_ADDIWB;
        ovf_reg_d = overflow;
      end
      S_ADDIWB:   state_d = ovf_reg_q ? S_EXCECAO : S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_EXCECAO:  state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; write strobes are suppressed while reset is held
  always_comb begin
    ULAcontrole = 3'b000;
    ULASrcA     = 1'b0;
    ULASrcB     = 2'b00;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 2'b00;
    excecao     = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite     = 1'b1;
        ULASrcB     = 2'b01;
        ULAcontrole = ALU_ADD;
        PCWrite     = 1'b1;
      end
      S_DECODE: begin
        ULASrcB     = 2'b11;
        ULAcontrole = ALU_ADD;
      end
      S_MEMADR: begin
        ULASrcA     = 1'b1;
        ULASrcB     = 2'b10;
        ULAcontrole = ALU_ADD;
      end
      S_MEMREAD:  IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ULASrcA     = 1'b1;
        ULAcontrole = funct_alu;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = ~ovf_reg_q;
      end
      S_BRANCH: begin
        ULASrcA     = 1'b1;
        ULAcontrole = ALU_SUB;
        PCSrc       = 2'b01;
        PCWrite     = zero;
      end
      S_ADDIEXEC: begin
        ULASrcA     = 1'b1;
        ULASrcB     = 2'b10;
        ULAcontrole = ALU_ADD;
      end
      S_ADDIWB:   RegWrite = ~ovf_reg_q;
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      S_EXCECAO:  excecao = 1'b1;
      default: ;
    endcase
    if (reset) begin
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      excecao  = 1'b0;
    end
  end

  assign estado = state_q;

endmodule
